// File: rtl/load_store_unit_if.sv
// Request, response and data_mem bus bundle for load_store_unit.
// master: pipeline/data_mem side; slave: the load/store unit.
interface load_store_unit_if;
    // Request channel (valid/ready)
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [31:0] req_offset;
    logic [31:0] req_wdata;

    // Response channel (single pulse, no backpressure)
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [1:0]  resp_fault_code;

    // data_mem bus
    logic        mem_en;
    logic        mem_we;
    logic        mem_se;
    logic [3:0]  mem_bs;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output req_valid,
        output req_we,
        output req_funct3,
        output req_base,
        output req_offset,
        output req_wdata,
        output mem_rdata,
        input  req_ready,
        input  resp_valid,
        input  resp_rdata,
        input  resp_fault,
        input  resp_fault_code,
        input  mem_en,
        input  mem_we,
        input  mem_se,
        input  mem_bs,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_funct3,
        input  req_base,
        input  req_offset,
        input  req_wdata,
        input  mem_rdata,
        output req_ready,
        output resp_valid,
        output resp_rdata,
        output resp_fault,
        output resp_fault_code,
        output mem_en,
        output mem_we,
        output mem_se,
        output mem_bs,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: EA generation, legality/alignment/RO checks, data_mem sequencing.
// Ports: clk, rst_n (async active-low), bus (load_store_unit_if.slave).
module load_store_unit #(
    parameter logic [31:0] RO_BASE  = 32'h0010_0000,
    parameter logic [31:0] RO_BYTES = 32'd12
) (
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_RESP
    } state_t;

    localparam logic [3:0] BS_BYTE = 4'b0001;
    localparam logic [3:0] BS_HALF = 4'b0010;
    localparam logic [3:0] BS_WORD = 4'b0011;

    localparam logic [1:0] FC_NONE  = 2'b00;
    localparam logic [1:0] FC_MISAL = 2'b01;
    localparam logic [1:0] FC_RO    = 2'b10;
    localparam logic [1:0] FC_ILL   = 2'b11;

    state_t      r_state;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_fault;
    logic [1:0]  r_resp_code;
    logic        r_mem_en;
    logic        r_mem_we;
    logic        r_mem_se;
    logic [3:0]  r_mem_bs;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;

    logic [31:0] w_ea;
    logic        w_legal;
    logic [3:0]  w_bs;
    logic        w_se;
    logic        w_misal;
    logic        w_ro_hit;
    logic [1:0]  w_code;
    logic        w_ready;
    logic        w_accept;

    assign w_ea = bus.req_base + bus.req_offset;

    // funct3 decode; stores only allow the signed encodings
    // and never request sign extension.
    always_comb begin
        w_legal = 1'b0;
        w_bs    = 4'b0000;
        w_se    = 1'b0;
        case (bus.req_funct3)
            3'b000: begin
                w_legal = 1'b1;
                w_bs    = BS_BYTE;
                w_se    = ~bus.req_we;
            end
            3'b001: begin
                w_legal = 1'b1;
                w_bs    = BS_HALF;
                w_se    = ~bus.req_we;
            end
            3'b010: begin
                w_legal = 1'b1;
                w_bs    = BS_WORD;
            end
            3'b100: begin
                w_legal = ~bus.req_we;
                w_bs    = BS_BYTE;
            end
            3'b101: begin
                w_legal = ~bus.req_we;
                w_bs    = BS_HALF;
            end
            default: begin
                w_legal = 1'b0;
            end
        endcase
    end

    assign w_misal = ((w_bs == BS_HALF) && w_ea[0])
                   | ((w_bs == BS_WORD) && (w_ea[1:0] != 2'b00));

    // Subtraction only evaluated meaningfully once EA >= RO_BASE,
    // so the window test cannot wrap.
    assign w_ro_hit = bus.req_we
                    && (w_ea >= RO_BASE)
                    && ((w_ea - RO_BASE) < RO_BYTES);

    always_comb begin
        if (!w_legal) begin
            w_code = FC_ILL;
        end else if (w_misal) begin
            w_code = FC_MISAL;
        end else if (w_ro_hit) begin
            w_code = FC_RO;
        end else begin
            w_code = FC_NONE;
        end
    end

    // rst_n gates ready so nothing looks accepted while held in reset.
    assign w_ready  = (r_state == S_IDLE) && rst_n;
    assign w_accept = bus.req_valid && w_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_fault <= 1'b0;
            r_resp_code  <= FC_NONE;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_se     <= 1'b0;
            r_mem_bs     <= 4'b0000;
            r_mem_addr   <= 32'h0;
            r_mem_wdata  <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_code != FC_NONE) begin
                            // Faulted: skip the bus entirely.
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_fault <= 1'b1;
                            r_resp_code  <= w_code;
                            r_resp_rdata <= 32'h0;
                        end else begin
                            r_state     <= S_ISSUE;
                            r_mem_en    <= 1'b1;
                            r_mem_we    <= bus.req_we;
                            r_mem_se    <= w_se;
                            r_mem_bs    <= w_bs;
                            r_mem_addr  <= w_ea;
                            r_mem_wdata <= bus.req_wdata;
                        end
                    end
                end
                S_ISSUE: begin
                    if (r_mem_we) begin
                        // Store commits on this edge.
                        r_state      <= S_RESP;
                        r_mem_en     <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_fault <= 1'b0;
                        r_resp_code  <= FC_NONE;
                        r_resp_rdata <= 32'h0;
                    end else begin
                        // Read edge; data returns next cycle.
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    r_state      <= S_RESP;
                    r_mem_en     <= 1'b0;
                    r_resp_valid <= 1'b1;
                    r_resp_fault <= 1'b0;
                    r_resp_code  <= FC_NONE;
                    r_resp_rdata <= bus.mem_rdata;
                end
                S_RESP: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready       = w_ready;
    assign bus.resp_valid      = r_resp_valid;
    assign bus.resp_rdata      = r_resp_rdata;
    assign bus.resp_fault      = r_resp_fault;
    assign bus.resp_fault_code = r_resp_code;
    assign bus.mem_en          = r_mem_en;
    assign bus.mem_we          = r_mem_we;
    assign bus.mem_se          = r_mem_se;
    assign bus.mem_bs          = r_mem_bs;
    assign bus.mem_addr        = r_mem_addr;
    assign bus.mem_wdata       = r_mem_wdata;

endmodule
